fetch_queue: RTL

Parametrised instruction prefetch queue, the next-generation fetch stage of the pipelined core. It sits between instruction memory and decode. It issues sequential fetch requests ahead of decode, with a bounded number in flight, and buffers returned instructions with their PC. On a branch, jump or jr redirect it flushes the buffer and silently discards stale in-flight responses. Decode stalls and variable-latency memory are absorbed, rather than the fixed lock-step fetch/decode register pair.

---
 rtl/core_pkg.sv | 14 +
 rtl/fetch_queue_mem.sv | 53 +++++
 rtl/fetch_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, reset PC and the fetch-queue entry payload.
package core_pkg;

    localparam int unsigned CORE_ADDR_W  = 32;
    localparam int unsigned CORE_INSTR_W = 32;
    localparam logic [CORE_ADDR_W-1:0] CORE_RESET_PC = CORE_ADDR_W'(32'h0000_0000);
    localparam int unsigned PC_INC = 4;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0]  pc;
        logic [CORE_INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Circular buffer of fetch entries with read/write pointers and a registered occupancy count.
module fetch_queue_mem
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  fq_entry_t               wdata_i,
    output fq_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage is reset so the head reads as zero while the queue is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers responses, flushes on redirect.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       MAX_OUTST = 2,
    parameter int unsigned       ADDR_W    = CORE_ADDR_W,
    parameter int unsigned       INSTR_W   = CORE_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(CORE_RESET_PC)
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic                     i_con_redirect,
    input  logic [ADDR_W-1:0]        i_addr_redirect,
    output logic                     o_con_req,
    output logic [ADDR_W-1:0]        o_addr_req,
    input  logic                     i_con_req_rdy,
    input  logic                     i_con_rvalid,
    input  logic [INSTR_W-1:0]       i_data_rdata,
    output logic                     o_con_valid,
    output logic [INSTR_W-1:0]       o_data_instr,
    output logic [ADDR_W-1:0]        o_addr_pc,
    output logic [ADDR_W-1:0]        o_addr_pc4,
    input  logic                     i_con_rdy,
    output logic [$clog2(DEPTH):0]   o_data_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] fill_pc_q, fill_pc_d;
    logic [OUT_W-1:0]  inflight_q, inflight_d;
    logic [OUT_W-1:0]  discard_q, discard_d;
    logic              en_q;

    logic              req_fire;
    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              clear;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] head_pc;
    fq_entry_t         wentry;
    fq_entry_t         rentry;

    // Reserve a slot for every outstanding request so responses can never overflow the queue.
    assign o_con_req = en_q && !i_con_redirect
                       && (32'(inflight_q) < MAX_OUTST)
                       && ((32'(count) + 32'(inflight_q)) < DEPTH);
    assign req_fire  = o_con_req && i_con_req_rdy;
    assign accept    = i_con_rvalid && (discard_q == '0);

    always_comb begin
        req_pc_d   = req_pc_q;
        fill_pc_d  = fill_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        bypass     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass     = accept && (count == '0) && !i_con_redirect;
`endif
        if (i_con_redirect) begin
            // Everything still in flight becomes stale, minus the response dropped this cycle.
            clear      = 1'b1;
            req_pc_d   = i_addr_redirect;
            fill_pc_d  = i_addr_redirect;
            inflight_d = inflight_q - OUT_W'(i_con_rvalid);
            discard_d  = inflight_q - OUT_W'(i_con_rvalid);
        end else begin
            if (req_fire) begin
                req_pc_d = req_pc_q + ADDR_W'(PC_INC);
            end
            inflight_d = inflight_q + OUT_W'(req_fire) - OUT_W'(i_con_rvalid);
            if (i_con_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - OUT_W'(1);
                end else begin
                    fill_pc_d = fill_pc_q + ADDR_W'(PC_INC);
                    push      = !(bypass && i_con_rdy);
                end
            end
            pop = (count != '0) && i_con_rdy;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            req_pc_q   <= RESET_PC;
            fill_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            en_q       <= 1'b0;
        end else begin
            req_pc_q   <= req_pc_d;
            fill_pc_q  <= fill_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            en_q       <= 1'b1;
        end
    end

    assign wentry.pc    = CORE_ADDR_W'(fill_pc_q);
    assign wentry.instr = CORE_INSTR_W'(i_data_rdata);

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (i_clk),
        .rst_n   (i_nrst),
        .clear_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (rentry),
        .count_o (count)
    );

    assign head_pc      = bypass ? fill_pc_q : ADDR_W'(rentry.pc);
    assign o_con_valid  = (count != '0) || bypass;
    assign o_data_instr = bypass ? i_data_rdata : INSTR_W'(rentry.instr);
    assign o_addr_pc    = head_pc;
    assign o_addr_pc4   = head_pc + ADDR_W'(PC_INC);
    assign o_addr_req   = req_pc_q;
    assign o_data_count = count;

endmodule
